// File: rtl/opsel_ctrl.sv
// Operand-select controller: debounced UP/DN/LOAD buttons drive a 3-bit SEL code with a change pulse.
// Optional auto-step input and period counter are built only with OPSEL_CTRL_AUTO_EN defined.

module opsel_ctrl_db #(
   parameter int DB_LIMIT = 1000000,
   parameter int CW       = $clog2(DB_LIMIT + 1)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic lvl_i,
   output logic evt_o
);
   typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} db_st_e;

   localparam logic [CW-1:0] CNT_TC  = CW'(DB_LIMIT - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   db_st_e        st_q;
   logic [CW-1:0] cnt_q;
   logic          evt_q;

   // cnt_q counts stable cycles already spent in a WAIT_* state; the DB_LIMIT-th one commits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q  <= IDLE;
         cnt_q <= '0;
         evt_q <= 1'b0;
      end else begin
         evt_q <= 1'b0;
         case (st_q)
            IDLE: begin
               cnt_q <= '0;
               if (lvl_i) st_q <= WAIT_PRESS;
            end
            WAIT_PRESS: begin
               if (!lvl_i) begin
                  st_q  <= IDLE;
                  cnt_q <= '0;
               end else if (cnt_q == CNT_TC) begin
                  st_q  <= PRESSED;
                  cnt_q <= '0;
                  evt_q <= 1'b1;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               cnt_q <= '0;
               if (!lvl_i) st_q <= WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
               if (lvl_i) begin
                  st_q  <= PRESSED;
                  cnt_q <= '0;
               end else if (cnt_q == CNT_TC) begin
                  st_q  <= IDLE;
                  cnt_q <= '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               st_q  <= IDLE;
               cnt_q <= '0;
            end
         endcase
      end
   end

   assign evt_o = evt_q;
endmodule

module opsel_ctrl #(
   parameter int DB_LIMIT    = 1000000,
   parameter int AUTO_PERIOD = 50000000
) (
   input  logic       OPSEL_CTRL_CLK_xi,
   input  logic       OPSEL_CTRL_RST_N_xi,
   input  logic       OPSEL_CTRL_BTN_UP_xi,
   input  logic       OPSEL_CTRL_BTN_DN_xi,
   input  logic       OPSEL_CTRL_LOAD_xi,
   input  logic [2:0] OPSEL_CTRL_SW_xi,
`ifdef OPSEL_CTRL_AUTO_EN
   input  logic       OPSEL_CTRL_AUTO_xi,
`endif
   output logic [2:0] OPSEL_CTRL_SEL_xo,
   output logic       OPSEL_CTRL_CHG_xo
);
   localparam int NBTN = 3;
   localparam int B_UP = 0;
   localparam int B_DN = 1;
   localparam int B_LD = 2;
`ifdef OPSEL_CTRL_AUTO_EN
   localparam int NSYNC = 7;
`else
   localparam int NSYNC = 6;
`endif

   logic             clk, rst_n;
   logic [NSYNC-1:0] raw, sync1_q, sync2_q;
   logic [NBTN-1:0]  btn_s, evt;
   logic [2:0]       sw_s;
   logic [2:0]       sel_q, sel_d;
   logic             chg_q;

   assign clk   = OPSEL_CTRL_CLK_xi;
   assign rst_n = OPSEL_CTRL_RST_N_xi;

`ifdef OPSEL_CTRL_AUTO_EN
   assign raw = {OPSEL_CTRL_AUTO_xi, OPSEL_CTRL_SW_xi, OPSEL_CTRL_LOAD_xi,
                 OPSEL_CTRL_BTN_DN_xi, OPSEL_CTRL_BTN_UP_xi};
`else
   assign raw = {OPSEL_CTRL_SW_xi, OPSEL_CTRL_LOAD_xi,
                 OPSEL_CTRL_BTN_DN_xi, OPSEL_CTRL_BTN_UP_xi};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   assign btn_s = sync2_q[2:0];
   assign sw_s  = sync2_q[5:3];

   for (genvar g = 0; g < NBTN; g++) begin : g_db
      opsel_ctrl_db #(.DB_LIMIT(DB_LIMIT)) u_db (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .lvl_i  (btn_s[g]),
         .evt_o  (evt[g])
      );
   end

`ifdef OPSEL_CTRL_AUTO_EN
   localparam int ACW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [ACW-1:0] AUTO_TC = ACW'(AUTO_PERIOD - 1);

   logic           auto_s, auto_tick;
   logic [ACW-1:0] acnt_q, acnt_d;

   assign auto_s = sync2_q[6];

   // Any button event restarts the auto interval so a manual step is never followed closely by an auto one.
   always_comb begin
      acnt_d    = acnt_q;
      auto_tick = 1'b0;
      if (!auto_s || (|evt)) begin
         acnt_d = '0;
      end else if (acnt_q == AUTO_TC) begin
         acnt_d    = '0;
         auto_tick = 1'b1;
      end else begin
         acnt_d = acnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acnt_q <= '0;
      else        acnt_q <= acnt_d;
   end
`endif

   always_comb begin
      sel_d = sel_q;
      if (evt[B_LD])
         sel_d = sw_s;
      else if (evt[B_UP] ^ evt[B_DN])
         sel_d = evt[B_UP] ? sel_q + 3'd1 : sel_q - 3'd1;
`ifdef OPSEL_CTRL_AUTO_EN
      else if (auto_tick)
         sel_d = sel_q + 3'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= 3'b000;
         chg_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
         chg_q <= (sel_d != sel_q);
      end
   end

   assign OPSEL_CTRL_SEL_xo = sel_q;
   assign OPSEL_CTRL_CHG_xo = chg_q;
endmodule
